// File: rtl/mmio_out_fifo_pkg.sv
// Shared constants for the MMIO output FIFO: default addresses and status bit layout.
// No logic; a helper function packs the status word.
// Imported by mmio_out_fifo.
package mmio_out_fifo_pkg;

  localparam logic [31:0] MMIO_DATA_ADDR_DEF   = 32'hFFFF_0000;
  localparam logic [31:0] MMIO_STATUS_ADDR_DEF = 32'hFFFF_0004;

  // Status register bit positions
  localparam int unsigned STAT_EMPTY   = 0;
  localparam int unsigned STAT_FULL    = 1;
  localparam int unsigned STAT_OVF     = 2;
  localparam int unsigned STAT_CNT_LSB = 8;

  // Pack occupancy and flags into the 32-bit status word
  function automatic logic [31:0] pack_status(input logic [7:0] cnt, input logic ovf,
                                              input logic full, input logic empty);
    logic [31:0] w;
    w = '0;
    w[STAT_CNT_LSB +: 8] = cnt;
    w[STAT_OVF]          = ovf;
    w[STAT_FULL]         = full;
    w[STAT_EMPTY]        = empty;
    return w;
  endfunction

endpackage

// File: rtl/mmio_fifo_ram.sv
// DEPTH x 32 storage for the MMIO output queue; one sync write port, one async read port.
// Latency: write lands on posedge, read is combinational.
// No backpressure and no reset; occupancy is tracked by the parent.
module mmio_fifo_ram #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned AW    = 3
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [31:0]   wdata,
  input  logic [AW-1:0] raddr,
  output logic [31:0]   rdata
);

  logic [31:0] mem [DEPTH];

  // Write the pushed word into its slot
  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/mmio_out_fifo.sv
// Snoops core stores to MMIO_DATA_ADDR and queues them for an external valid/ready consumer.
// Latency: word stored in cycle N appears on out_data/out_valid in cycle N+1.
// Never stalls the core: a push into a full queue (without a same-cycle pop) is dropped and sets
// sticky overflow. Optional status register under `MMIO_OUT_FIFO_STATUS_EN.
module mmio_out_fifo
  import mmio_out_fifo_pkg::*;
#(
  parameter int unsigned DEPTH            = 8,
  parameter logic [31:0] MMIO_DATA_ADDR   = MMIO_DATA_ADDR_DEF,
  parameter logic [31:0] MMIO_STATUS_ADDR = MMIO_STATUS_ADDR_DEF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        mem_write,
  input  logic        mem_read,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        rdata_hit,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        overflow
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [CW-1:0] count, count_nxt;
  logic          empty, full;
  logic          push_req, push, pop, ovf_set, ovf_clr;
  logic [31:0]   ram_rdata;
  logic [31:0]   status_word;

  assign empty    = (count == '0);
  assign full     = (count == FULL_CNT);
  assign push_req = mem_write && (addr == MMIO_DATA_ADDR);
  assign pop      = out_valid && out_ready;
  // A full queue still accepts a push when the head leaves in the same cycle
  assign push     = push_req && (!full || pop);
  assign ovf_set  = push_req && full && !pop;

  assign out_valid = !empty;
  assign out_data  = empty ? 32'h0 : ram_rdata;

  assign status_word = pack_status(8'(count), overflow, full, empty);

`ifdef MMIO_OUT_FIFO_STATUS_EN
  assign ovf_clr   = mem_write && (addr == MMIO_STATUS_ADDR) && wdata[STAT_OVF];
  assign rdata_hit = mem_read && (addr == MMIO_STATUS_ADDR);
  assign rdata     = status_word;
`else
  logic unused_status;
  assign unused_status = ^{mem_read, status_word, (addr == MMIO_STATUS_ADDR)};
  assign ovf_clr   = 1'b0;
  assign rdata_hit = 1'b0;
  assign rdata     = 32'h0;
`endif

  mmio_fifo_ram #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_ram (
    .clk   (clk),
    .we    (push),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (ram_rdata)
  );

  // Occupancy next-state: simultaneous push and pop leaves it unchanged
  always_comb begin
    count_nxt = count;
    if (push && !pop)      count_nxt = count + CW'(1);
    else if (!push && pop) count_nxt = count - CW'(1);
  end

  // Pointer and occupancy registers; pointers wrap modulo DEPTH
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // Sticky overflow; a dropped push in the same cycle beats a software clear
  always_ff @(posedge clk or negedge reset) begin
    if (!reset)       overflow <= 1'b0;
    else if (ovf_set) overflow <= 1'b1;
    else if (ovf_clr) overflow <= 1'b0;
  end

endmodule

// File: tb/tb_mmio_out_fifo.sv
// Self-checking bench for mmio_out_fifo: directed scenarios followed by random traffic,
// compared every cycle against a queue-based reference model.
// Builds with or without `MMIO_OUT_FIFO_STATUS_EN.
module tb_mmio_out_fifo;

  localparam int DEPTH = 8;
  localparam logic [31:0] DA = 32'hFFFF_0000;
  localparam logic [31:0] SA = 32'hFFFF_0004;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        mem_write = 1'b0;
  logic        mem_read = 1'b0;
  logic [31:0] addr = 32'h0;
  logic [31:0] wdata = 32'h0;
  logic        out_ready = 1'b0;
  logic [31:0] rdata;
  logic        rdata_hit;
  logic [31:0] out_data;
  logic        out_valid;
  logic        overflow;

  int n_pass = 0;
  int n_total = 0;

  // Reference model: a plain queue of accepted words plus the sticky flag
  logic [31:0] q[$];
  logic        m_ovf = 1'b0;

  mmio_out_fifo #(
    .DEPTH            (DEPTH),
    .MMIO_DATA_ADDR   (DA),
    .MMIO_STATUS_ADDR (SA)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .mem_write (mem_write),
    .mem_read  (mem_read),
    .addr      (addr),
    .wdata     (wdata),
    .rdata     (rdata),
    .rdata_hit (rdata_hit),
    .out_data  (out_data),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .overflow  (overflow)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  function automatic logic [31:0] model_status();
    int sz;
    sz = q.size();
    return (32'(sz) << 8) | ({29'b0, m_ovf, 2'b00}) |
           ((sz == DEPTH) ? 32'h2 : 32'h0) | ((sz == 0) ? 32'h1 : 32'h0);
  endfunction

  // One bus cycle: drive at posedge+1, check at negedge, advance model, return at next posedge+1
  task automatic cyc(input logic mw, input logic mr, input logic [31:0] a,
                     input logic [31:0] wd, input logic rdy, input string tag);
    logic popped, preq, clr;
    int   sz;
    mem_write = mw; mem_read = mr; addr = a; wdata = wd; out_ready = rdy;
    #4;
    sz = q.size();
    chk({tag, ":valid"}, {31'b0, out_valid}, {31'b0, (sz != 0)});
    chk({tag, ":data"}, out_data, (sz != 0) ? q[0] : 32'h0);
    chk({tag, ":ovf"}, {31'b0, overflow}, {31'b0, m_ovf});
`ifdef MMIO_OUT_FIFO_STATUS_EN
    chk({tag, ":rdata"}, rdata, model_status());
    chk({tag, ":hit"}, {31'b0, rdata_hit}, {31'b0, (mr && a == SA)});
    clr = mw && (a == SA) && wd[2];
`else
    chk({tag, ":rdata"}, rdata, 32'h0);
    chk({tag, ":hit"}, {31'b0, rdata_hit}, 32'h0);
    clr = 1'b0;
`endif
    popped = (sz != 0) && rdy;
    preq   = mw && (a == DA);
    if (popped) void'(q.pop_front());
    if (preq && (sz < DEPTH || popped)) q.push_back(wd);
    if (preq && sz == DEPTH && !popped) m_ovf = 1'b1;
    else if (clr)                       m_ovf = 1'b0;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse in the middle of a cycle, checked before any clock edge
  task automatic mid_reset(input string tag);
    mem_write = 1'b0; mem_read = 1'b0; out_ready = 1'b0;
    #2 reset = 1'b0;
    #1;
    chk({tag, ":valid"}, {31'b0, out_valid}, 32'h0);
    chk({tag, ":data"}, out_data, 32'h0);
    chk({tag, ":ovf"}, {31'b0, overflow}, 32'h0);
    q.delete();
    m_ovf = 1'b0;
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] seq5 [5];

  initial begin
    int r;
    logic [31:0] a;
    seq5 = '{32'd1, 32'd1, 32'd2, 32'd3, 32'd5};

    // Reset state
    #12;
    chk("rst:valid", {31'b0, out_valid}, 32'h0);
    chk("rst:data", out_data, 32'h0);
    chk("rst:ovf", {31'b0, overflow}, 32'h0);
    @(posedge clk);
    #3 reset = 1'b1;
    @(posedge clk);
    #1;

    // Order: 1,1,2,3,5 queued with consumer stalled, then drained
    foreach (seq5[i]) cyc(1'b1, 1'b0, DA, seq5[i], 1'b0, "order_push");
    for (int i = 0; i < 6; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "order_drain");

    // Decode: near-miss addresses must not push
    cyc(1'b1, 1'b0, 32'hFFFF_0008, 32'hDEAD_0001, 1'b1, "decode_8");
    cyc(1'b1, 1'b0, 32'h0000_0000, 32'hDEAD_0002, 1'b1, "decode_0");
    cyc(1'b1, 1'b0, 32'h7FFF_0000, 32'hDEAD_0003, 1'b1, "decode_msb");
    cyc(1'b0, 1'b0, DA, 32'hDEAD_0004, 1'b1, "decode_nowr");

    // Full with simultaneous push and pop: 0xAA accepted, no overflow, emerges 8th
    for (int i = 0; i < DEPTH; i++) cyc(1'b1, 1'b0, DA, 32'(100 + i), 1'b0, "full_fill");
    cyc(1'b1, 1'b0, DA, 32'h0000_00AA, 1'b1, "full_simul");
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "full_drain");

    // Overflow: 9 stores into 8 slots, value 8 dropped
    for (int i = 0; i < 9; i++) cyc(1'b1, 1'b0, DA, 32'(i), 1'b0, "ovf_fill");
    for (int i = 0; i < DEPTH + 1; i++) cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "ovf_drain");

    // Three queued with prior overflow, then status read and overflow clear
    for (int i = 0; i < 3; i++) cyc(1'b1, 1'b0, DA, 32'(32'h11 * (i + 1)), 1'b0, "stat_fill");
    mem_write = 1'b0; mem_read = 1'b1; addr = SA; out_ready = 1'b0;
    #4;
`ifdef MMIO_OUT_FIFO_STATUS_EN
    chk("stat:word", rdata, 32'h0000_0304);
    chk("stat:hit", {31'b0, rdata_hit}, 32'h1);
`else
    chk("stat:word", rdata, 32'h0);
    chk("stat:hit", {31'b0, rdata_hit}, 32'h0);
`endif
    @(posedge clk);
    #1;
    cyc(1'b1, 1'b0, SA, 32'h0000_0004, 1'b0, "stat_clr");
    cyc(1'b0, 1'b1, SA, 32'h0, 1'b0, "stat_after");

    // Asynchronous reset with words queued
    mid_reset("midrst");
    cyc(1'b0, 1'b0, 32'h0, 32'h0, 1'b1, "post_rst");

    // Random traffic: slow consumer first (fills, overflows), then fast consumer
    for (int n = 0; n < 600; n++) begin
      r = $urandom_range(0, 9);
      case (r)
        0, 1, 2, 3, 4, 5: a = DA;
        6:                a = SA;
        7:                a = 32'hFFFF_0008;
        8:                a = 32'h0;
        default:          a = DA ^ (32'h1 << $urandom_range(0, 31));
      endcase
      cyc(($urandom_range(0, 3) != 0), ($urandom_range(0, 1) == 1), a, $urandom,
          (n < 300) ? ($urandom_range(0, 3) == 0) : ($urandom_range(0, 3) != 0), "rand");
      if (n == 450) mid_reset("rand_rst");
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
